// File: rtl/bus_wb_param_if.sv
// Wishbone B4 classic-cycle signal bundle for bus_wb_param.
//
// Purpose: groups the Wishbone signals between the bus master
// (bus_wb_param) and the external bus/slave.
//
// Signals (names follow the Wishbone master's point of view):
//   ACK_I   slave -> master  acknowledge
//   ERR_I   slave -> master  error (only used when BUS_WB_ERR_EN is defined)
//   DAT_I   slave -> master  read data, DATA_WIDTH bits
//   ADR_O   master -> slave  byte address, always aligned to the bus width
//   DAT_O   master -> slave  write data, DATA_WIDTH bits
//   SEL_O   master -> slave  byte selects, DATA_WIDTH/8 bits
//   CYC_O   master -> slave  cycle
//   STB_O   master -> slave  strobe
//   WE_O    master -> slave  write enable
interface bus_wb_param_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  ACK_I;
    logic                  ERR_I;
    logic [DATA_WIDTH-1:0] DAT_I;
    logic [31:0]           ADR_O;
    logic [DATA_WIDTH-1:0] DAT_O;
    logic [BYTES-1:0]      SEL_O;
    logic                  CYC_O;
    logic                  STB_O;
    logic                  WE_O;

    modport master (
        input  ACK_I, ERR_I, DAT_I,
        output ADR_O, DAT_O, SEL_O, CYC_O, STB_O, WE_O
    );

    modport slave (
        output ACK_I, ERR_I, DAT_I,
        input  ADR_O, DAT_O, SEL_O, CYC_O, STB_O, WE_O
    );
endinterface

// File: rtl/bus_wb_param.sv
// bus_wb_param: parametrised Wishbone B4 classic-cycle bus master.
//
// Purpose: accepts one CPU load/store op (byte, halfword or word, any
// alignment), splits it into 1..4 bus-width beats with byte selects,
// assembles read data little-endian and sign/zero-extends it to 32 bits.
// An optional per-beat timeout aborts a stalled bus.
//
// Parameters:
//   DATA_WIDTH      bus width in bits: 8, 16 or 32
//   TIMEOUT_CYCLES  max strobe cycles per beat without ACK_I; 0 = no timeout
//
// Optional feature macro: BUS_WB_ERR_EN -- when defined, ERR_I during a
// strobe aborts the op (priority over ACK_I). When undefined ERR_I is unused.
//
// Ports:
//   CLK_I   clock, rising edge
//   RST_I   asynchronous reset, active low
//   I_en    op request, sampled only while idle
//   I_op    op code (BUSOP_* below)
//   I_addr  byte address of the access
//   I_data  write data, right-aligned
//   O_data  extended read result (updated only when a read completes)
//   O_busy  op in progress
//   O_err   last op aborted; sticky until the next accepted op
//   wb      Wishbone master modport
//
// Op codes: READB=0 READBU=1 READH=2 READHU=3 READW=4 WRITEB=5 WRITEH=6 WRITEW=7
module bus_wb_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic           CLK_I,
    input  logic           RST_I,
    input  logic           I_en,
    input  logic [2:0]     I_op,
    input  logic [31:0]    I_addr,
    input  logic [31:0]    I_data,
    output logic [31:0]    O_data,
    output logic           O_busy,
    output logic           O_err,
    bus_wb_param_if.master wb
);
    localparam int         BYTES    = DATA_WIDTH / 8;
    localparam int         LB       = $clog2(BYTES);
    localparam logic [1:0] OFF_MASK = 2'(BYTES - 1);

    localparam logic [2:0] BUSOP_READB  = 3'd0;
    localparam logic [2:0] BUSOP_READBU = 3'd1;
    localparam logic [2:0] BUSOP_READH  = 3'd2;
    localparam logic [2:0] BUSOP_READHU = 3'd3;
    localparam logic [2:0] BUSOP_READW  = 3'd4;
    localparam logic [2:0] BUSOP_WRITEB = 3'd5;
    localparam logic [2:0] BUSOP_WRITEH = 3'd6;
    localparam logic [2:0] BUSOP_WRITEW = 3'd7;

    // START is the cycle after acceptance; GAP is the one-cycle strobe
    // drop between beats while CYC_O stays asserted.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BEAT,
        S_GAP,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] odata_q, odata_d;
    logic [31:0] tmo_q, tmo_d;
    logic [1:0]  beat_q, beat_d;
    logic        err_q, err_d;

    logic                  abort;
    logic [1:0]            off;
    logic [2:0]            size;
    logic [3:0]            span;
    logic [2:0]            nbeats;
    logic                  last_beat;
    logic                  wr;
    logic [31:0]           beat_adr;
    logic [BYTES-1:0]      beat_sel;
    logic [DATA_WIDTH-1:0] beat_dat;
    logic [31:0]           rbuf_cap;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            BUSOP_READB, BUSOP_READBU, BUSOP_READH, BUSOP_READHU,
            BUSOP_READW, BUSOP_WRITEB, BUSOP_WRITEH, BUSOP_WRITEW: op_legal = 1'b1;
            default:                                                op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] op_size(input logic [2:0] op);
        case (op)
            BUSOP_READB, BUSOP_READBU, BUSOP_WRITEB: op_size = 3'd1;
            BUSOP_READH, BUSOP_READHU, BUSOP_WRITEH: op_size = 3'd2;
            default:                                 op_size = 3'd4;
        endcase
    endfunction

    function automatic logic op_is_write(input logic [2:0] op);
        op_is_write = (op == BUSOP_WRITEB) || (op == BUSOP_WRITEH) || (op == BUSOP_WRITEW);
    endfunction

    // Sign- or zero-extend the assembled read bytes to 32 bits.
    function automatic logic [31:0] extend_read(input logic [31:0] raw, input logic [2:0] op);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = signed'(raw[7:0]);
        h = signed'(raw[15:0]);
        case (op)
            BUSOP_READB:  r = 32'(b);
            BUSOP_READH:  r = 32'(h);
            BUSOP_READBU: r = signed'({24'd0, raw[7:0]});
            BUSOP_READHU: r = signed'({16'd0, raw[15:0]});
            default:      r = signed'(raw);
        endcase
        extend_read = unsigned'(r);
    endfunction

    // Beat geometry and lane mapping for the current beat.
    always_comb begin : beat_map
        int         g;
        int         k;
        logic [1:0] kk;
        g         = 0;
        k         = 0;
        kk        = 2'd0;
        off       = addr_q[1:0] & OFF_MASK;
        size      = op_size(op_q);
        span      = 4'(off) + 4'(size) + 4'(BYTES - 1);
        nbeats    = 3'(span >> LB);
        last_beat = ({1'b0, beat_q} == (nbeats - 3'd1));
        wr        = op_is_write(op_q);
        beat_adr  = (addr_q & ~32'(BYTES - 1)) + (32'(beat_q) << LB);
        beat_sel  = '0;
        beat_dat  = '0;
        rbuf_cap  = rbuf_q;
        for (int l = 0; l < BYTES; l++) begin
            // g: lane position counted from lane 0 of beat 0; k: access byte index
            g  = int'(beat_q) * BYTES + l;
            k  = g - int'(off);
            kk = k[1:0];
            if (k >= 0 && k < int'(size)) begin
                beat_sel[l] = 1'b1;
                if (wr) begin
                    beat_dat[8*l +: 8] = wdata_q[8*kk +: 8];
                end
                rbuf_cap[8*kk +: 8] = wb.DAT_I[8*l +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        odata_d = odata_q;
        tmo_d   = tmo_q;
        beat_d  = beat_q;
        err_d   = err_q;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_en && op_legal(I_op)) begin
                    op_d    = I_op;
                    addr_d  = I_addr;
                    wdata_d = I_data;
                    beat_d  = 2'd0;
                    err_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tmo_d   = 32'd0;
                state_d = S_BEAT;
            end
            S_BEAT: begin
`ifdef BUS_WB_ERR_EN
                if (wb.ERR_I) begin
                    abort = 1'b1;
                end else
`endif
                if (wb.ACK_I) begin
                    rbuf_d = rbuf_cap;
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        state_d = S_GAP;
                    end
                end else if (TIMEOUT_CYCLES != 0 && tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                // timeout counter restarts on every strobe rise
                tmo_d   = 32'd0;
                state_d = S_BEAT;
            end
            S_DONE: begin
                if (!wr) begin
                    odata_d = extend_read(rbuf_q, op_q);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wb.CYC_O = (state_q == S_BEAT) || (state_q == S_GAP);
        wb.STB_O = (state_q == S_BEAT);
        wb.WE_O  = ((state_q == S_BEAT) || (state_q == S_GAP)) && wr;
        wb.ADR_O = (state_q == S_BEAT) ? beat_adr : 32'd0;
        wb.SEL_O = (state_q == S_BEAT) ? beat_sel : '0;
        wb.DAT_O = (state_q == S_BEAT) ? beat_dat : '0;
        O_busy   = (state_q != S_IDLE);
        O_err    = err_q;
        O_data   = odata_q;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rbuf_q  <= 32'd0;
            odata_q <= 32'd0;
            tmo_q   <= 32'd0;
            beat_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            odata_q <= odata_d;
            tmo_q   <= tmo_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/bus_wb_param.md
Name: bus_wb_param

Overview:
Parametrised Wishbone B4 classic-cycle bus master between the CPU load/store path and the external bus. It takes one CPU bus op (byte, halfword or word, read or write, at any alignment) and splits it into one or more data-width beats. Each beat drives byte selects. The block assembles and sign- or zero-extends read data and can abort a stalled bus with a timeout. It replaces the fixed 8-bit adapter and serves 8-, 16- and 32-bit buses.

Parameters:
DATA_WIDTH, 8, bus data width in bits; legal values are 8, 16 and 32. B = DATA_WIDTH/8 bytes per beat.
TIMEOUT_CYCLES, 0, maximum cycles to wait for ACK_I per beat; 0 disables the timeout.

Ports:
CLK_I  in  1  clock; all logic on the rising edge
RST_I  in  1  reset, asynchronous, active-low (0 = reset)
I_en  in  1  op request qualifier; sampled only in IDLE
I_op  in  3  BUSOP_* code from busdefs.vh
I_addr  in  32  byte address of the access
I_data  in  32  write data, right-aligned
O_data  out  32  read result, extended to 32 bits
O_busy  out  1  op in progress
O_err  out  1  last op aborted; sticky until next accepted op
ACK_I  in  1  Wishbone acknowledge
ERR_I  in  1  Wishbone error (used only with the optional feature)
DAT_I  in  DATA_WIDTH  Wishbone read data
ADR_O  out  32  Wishbone address, always B-aligned
DAT_O  out  DATA_WIDTH  Wishbone write data
SEL_O  out  B  Wishbone byte selects
CYC_O, STB_O, WE_O  out  1 each  Wishbone cycle, strobe and write enable

Behaviour:
- Reset (async, RST_I=0): all outputs 0; state IDLE; O_data and the internal assembly buffer cleared. Reset mid-op abandons the op immediately, with no completion and no O_err.
- Size S: READB/READBU/WRITEB = 1; READH/READHU/WRITEH = 2; READW/WRITEW = 4. Undefined I_op in IDLE is ignored (stay IDLE, O_busy stays 0).
- Beat count N = ((I_addr mod B) + S + B - 1) / B, giving 1..4 beats. Beat n uses ADR_O = (I_addr with the low log2(B) bits cleared) + n*B.
- Lane mapping: access byte k (address I_addr+k) uses lane (I_addr+k) mod B of beat floor(((I_addr mod B)+k)/B). SEL_O bits are set only for lanes carrying access bytes. Unselected DAT_O lanes are 0.
- I_addr, I_op and I_data are latched at acceptance. Later changes to the inputs, including I_en going low, do not affect an op in flight.
- States:
  - IDLE: if I_en is high with a legal op, latch the op. Next cycle: O_busy=1, O_err=0, go to BEAT.
  - BEAT: CYC_O=1, STB_O=1, WE_O set from the op, and ADR_O/SEL_O/DAT_O set for the current beat. Hold until ACK_I.
    - On ACK_I with beats remaining: capture the selected read lanes and advance the beat. The next beat's ADR_O/SEL_O/DAT_O appear the next cycle. STB_O drops for exactly one cycle between beats. CYC_O stays 1.
    - On ACK_I on the final beat: go to DONE.
  - DONE: CYC_O=STB_O=WE_O=0 and SEL_O=0. O_data is updated (reads only) and O_busy=0 in the same cycle. Return to IDLE. A new op can be accepted the following cycle.
- Read result: the assembled S bytes, little-endian, bit 0 = byte at I_addr. READB/READH sign-extend from bit 8S-1; READBU/READHU and READW do not extend. O_data changes only in DONE of a read; partial results are never visible. Writes leave O_data unchanged.
- Minimum latency, measured from the acceptance edge to O_busy falling: 1 + N*2 + 1 - 1 = 2N+1 cycles with ACK returned in the first strobe cycle.
- Timeout (TIMEOUT_CYCLES > 0): a counter restarts on each beat's STB rise. If TIMEOUT_CYCLES cycles pass without ACK_I, the op aborts: all strobes drop, O_err=1, O_busy=0, O_data unchanged, state IDLE.
- ACK_I outside BEAT is ignored.

Optional Feature:
BUS_WB_ERR_EN: when defined, ERR_I in BEAT terminates the beat. It is handled like a timeout abort: strobes drop, O_err=1, O_busy=0, O_data unchanged, IDLE. ERR_I has priority over ACK_I in the same cycle. When not defined, ERR_I is ignored and not read.

Test Plan:
- DATA_WIDTH=8, READW at 0x100, memory bytes 11,22,33,44: 4 beats at ADR_O 0x100..0x103 with SEL_O=1 -> O_data=0x44332211, O_busy high for 9 cycles with zero-wait ACK.
- DATA_WIDTH=32, READH at 0x203, byte 0x203=0x80, byte 0x204=0xFF: beats (0x200, SEL 1000) then (0x204, SEL 0001) -> O_data=0xFFFFFF80. The same access as READHU gives 0x0000FF80.
- DATA_WIDTH=16, WRITEB at 0x11 with I_data=0x000000AB: one beat, ADR_O=0x10, SEL_O=10, DAT_O=0xAB00, WE_O=1 -> completes in 3 cycles.
- TIMEOUT_CYCLES=5, READB with ACK_I held low: STB_O drops after 5 strobe cycles, O_err=1, O_data unchanged. The next accepted op clears O_err.
- RST_I pulsed low during beat 2 of a DATA_WIDTH=8 WRITEW: CYC/STB/WE/SEL go to 0 asynchronously, O_busy=0, O_err=0. A following READB completes normally.
- BUS_WB_ERR_EN defined, ERR_I and ACK_I asserted together on beat 1 of a 2-beat op: abort, O_err=1, no second beat issued.
